// File: rtl/jedro_1_test_monitor.sv
// ============================================================================
// Module      : jedro_1_test_monitor
// Description : Run controller for jedro_1 core benches. It resets and runs the
//               core, then checks register-file slots against expected values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jedro_1_test_monitor #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHECKS   = 4,
    parameter int MAX_CYCLES   = 32,
    parameter int RESET_CYCLES = 3,
    parameter int DRAIN_CYCLES = 3,
    parameter bit REQUIRE_HALT = 1'b1,
    localparam int FIDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           start_i,
    input  logic                           illegal_instr_i,
    input  logic [DATA_WIDTH-1:0]          rf_rdata_i,
    input  logic [5*NUM_CHECKS-1:0]        chk_addr_i,
    input  logic [DATA_WIDTH*NUM_CHECKS-1:0] chk_exp_i,
    input  logic [NUM_CHECKS-1:0]          chk_en_i,
    output logic                           core_rstn_o,
    output logic [4:0]                     rf_raddr_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           pass_o,
    output logic                           timeout_o,
    output logic [FIDX_W-1:0]              fail_idx_o,
    output logic [DATA_WIDTH-1:0]          fail_data_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // With no drain phase the run hands over straight to checking.
    localparam logic [2:0] S_AFTER_RUN = (DRAIN_CYCLES == 0) ? S_CHECK : S_DRAIN;

    // One shared phase counter, wide enough for the longest phase.
    localparam int CNT_MAX_A = (MAX_CYCLES > RESET_CYCLES) ? MAX_CYCLES : RESET_CYCLES;
    localparam int CNT_MAX_B = (DRAIN_CYCLES > NUM_CHECKS) ? DRAIN_CYCLES : NUM_CHECKS;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CHK_LAST   = CNT_W'(NUM_CHECKS - 1);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  fail_q, fail_d;
    logic [FIDX_W-1:0]     fail_idx_q, fail_idx_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

    logic [4:0]            slot_addr [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] slot_exp  [NUM_CHECKS];
    logic [FIDX_W-1:0]     slot_idx;
    logic                  mismatch;

    for (genvar k = 0; k < NUM_CHECKS; k++) begin : g_slots
        assign slot_addr[k] = chk_addr_i[5*k +: 5];
        assign slot_exp[k]  = chk_exp_i[DATA_WIDTH*k +: DATA_WIDTH];
    end

    assign slot_idx = cnt_q[FIDX_W-1:0];
    assign mismatch = (state_q == S_CHECK) && chk_en_i[slot_idx]
                      && (rf_rdata_i != slot_exp[slot_idx]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            fail_q      <= 1'b0;
            fail_idx_q  <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
            fail_q      <= fail_d;
            fail_idx_q  <= fail_idx_d;
            fail_data_q <= fail_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        fail_d      = fail_q;
        fail_idx_d  = fail_idx_q;
        fail_data_d = fail_data_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_RESET;
                    cnt_d       = '0;
                    timeout_d   = 1'b0;
                    fail_d      = 1'b0;
                    fail_idx_d  = '0;
                    fail_data_d = '0;
                end
            end
            S_RESET: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                // A halt on the budget's last cycle still counts as a halt.
                if (illegal_instr_i) begin
                    state_d = S_AFTER_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == RUN_LAST) begin
                    state_d   = S_AFTER_RUN;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                end
            end
            S_CHECK: begin
                cnt_d = cnt_q + 1'b1;
                if (mismatch && !fail_q) begin
                    fail_d      = 1'b1;
                    fail_idx_d  = slot_idx;
                    fail_data_d = rf_rdata_i;
                end
                if (cnt_q == CHK_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        core_rstn_o = (state_q == S_RUN) || (state_q == S_DRAIN)
                      || (state_q == S_CHECK) || (state_q == S_DONE);
        busy_o      = (state_q == S_RESET) || (state_q == S_RUN)
                      || (state_q == S_DRAIN) || (state_q == S_CHECK);
        done_o      = (state_q == S_DONE);
        pass_o      = (state_q == S_DONE) && !fail_q && !(timeout_q && REQUIRE_HALT);
        timeout_o   = timeout_q;
        fail_idx_o  = fail_idx_q;
        fail_data_o = fail_data_q;
        rf_raddr_o  = (state_q == S_CHECK) ? slot_addr[slot_idx] : 5'd0;
    end

endmodule

`default_nettype wire

// File: tb/tb_jedro_1_test_monitor.sv
// ============================================================================
// Module      : tb_jedro_1_test_monitor
// Description : Directed bench for jedro_1_test_monitor with a behavioural core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jedro_1_test_monitor;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic        illegal_instr_i;
    logic [31:0] rf_rdata_i;
    logic [19:0] chk_addr_i;
    logic [127:0] chk_exp_i;
    logic [3:0]  chk_en_i;

    logic        core_rstn_o, busy_o, done_o, pass_o, timeout_o;
    logic [4:0]  rf_raddr_o;
    logic [1:0]  fail_idx_o;
    logic [31:0] fail_data_o;

    logic        nh_core_rstn_o, nh_busy_o, nh_done_o, nh_pass_o, nh_timeout_o;
    logic [4:0]  nh_rf_raddr_o;
    logic [1:0]  nh_fail_idx_o;
    logic [31:0] nh_fail_data_o;

    int n_vec = 0;
    int n_bad = 0;
    int halt_at;
    int ccnt = 0;
    int lat, low;
    logic [63:0] r0_fidx, r0_fdata, r0_busy;

    always #5 clk_i = ~clk_i;

    jedro_1_test_monitor #(.REQUIRE_HALT(1'b1)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .illegal_instr_i(illegal_instr_i), .rf_rdata_i(rf_rdata_i),
        .chk_addr_i(chk_addr_i), .chk_exp_i(chk_exp_i), .chk_en_i(chk_en_i),
        .core_rstn_o(core_rstn_o), .rf_raddr_o(rf_raddr_o), .busy_o(busy_o),
        .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .fail_idx_o(fail_idx_o), .fail_data_o(fail_data_o)
    );

    jedro_1_test_monitor #(.REQUIRE_HALT(1'b0)) dut_nh (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .illegal_instr_i(illegal_instr_i), .rf_rdata_i(rf_rdata_i),
        .chk_addr_i(chk_addr_i), .chk_exp_i(chk_exp_i), .chk_en_i(chk_en_i),
        .core_rstn_o(nh_core_rstn_o), .rf_raddr_o(nh_rf_raddr_o), .busy_o(nh_busy_o),
        .done_o(nh_done_o), .pass_o(nh_pass_o), .timeout_o(nh_timeout_o),
        .fail_idx_o(nh_fail_idx_o), .fail_data_o(nh_fail_data_o)
    );

    // Behavioural core: x7 becomes 15 on its 4th cycle out of reset, other
    // registers read 100+index, and it halts on cycle halt_at.
    always @(posedge clk_i) begin
        if (!core_rstn_o) ccnt <= 0;
        else              ccnt <= ccnt + 1;
    end

    assign illegal_instr_i = core_rstn_o && (ccnt == halt_at);
    assign rf_rdata_i = (rf_raddr_o == 5'd7) ? ((core_rstn_o && ccnt >= 3) ? 32'd15 : 32'd0)
                                             : 32'd100 + {27'd0, rf_raddr_o};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int k, input logic [4:0] a, input logic [31:0] e, input logic en);
        chk_addr_i[5*k +: 5]  = a;
        chk_exp_i[32*k +: 32] = e;
        chk_en_i[k]           = en;
    endtask

    // Starts a run and counts cycles from the start sample edge to done_o.
    task automatic do_run(input int pulse_at);
        @(negedge clk_i) start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        lat = 0;
        low = 0;
        r0_fidx  = 64'(fail_idx_o);
        r0_fdata = 64'(fail_data_o);
        r0_busy  = 64'(busy_o);
        while (!done_o && lat < 200) begin
            if (!core_rstn_o) low++;
            start_i = (lat == pulse_at);
            @(posedge clk_i);
            #1;
            lat++;
        end
        start_i = 1'b0;
    endtask

    initial begin
        rstn_i     = 1'b0;
        start_i    = 1'b0;
        halt_at    = 1000;
        chk_addr_i = '0;
        chk_exp_i  = '0;
        chk_en_i   = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_core_rstn", 64'(core_rstn_o), 0);
        chk("rst_busy",      64'(busy_o), 0);
        chk("rst_done",      64'(done_o), 0);
        chk("rst_pass",      64'(pass_o), 0);
        chk("rst_timeout",   64'(timeout_o), 0);
        chk("rst_fidx",      64'(fail_idx_o), 0);
        chk("rst_fdata",     64'(fail_data_o), 0);
        chk("rst_raddr",     64'(rf_raddr_o), 0);
        @(negedge clk_i) rstn_i = 1'b1;

        // Halting program, single matching slot: R = 11 run cycles.
        halt_at = 10;
        set_slot(0, 5'd7, 32'd15, 1'b1);
        do_run(-1);
        chk("t1_latency",   64'(lat), 21);
        chk("t1_core_low",  64'(low), 3);
        chk("t1_done",      64'(done_o), 1);
        chk("t1_pass",      64'(pass_o), 1);
        chk("t1_timeout",   64'(timeout_o), 0);
        chk("t1_fidx",      64'(fail_idx_o), 0);
        chk("t1_core_rstn", 64'(core_rstn_o), 1);

        set_slot(1, 5'd3, 32'd103, 1'b1);
        set_slot(2, 5'd7, 32'd14, 1'b1);
        do_run(-1);
        chk("t2_pass",  64'(pass_o), 0);
        chk("t2_fidx",  64'(fail_idx_o), 2);
        chk("t2_fdata", 64'(fail_data_o), 15);
        chk("t2_timeout", 64'(timeout_o), 0);

        // A later mismatching slot must not overwrite the first failure.
        set_slot(3, 5'd4, 32'd0, 1'b1);
        do_run(-1);
        chk("t2b_clr_fidx",  r0_fidx, 0);
        chk("t2b_clr_fdata", r0_fdata, 0);
        chk("t2b_pass",  64'(pass_o), 0);
        chk("t2b_fidx",  64'(fail_idx_o), 2);
        chk("t2b_fdata", 64'(fail_data_o), 15);

        // Back-to-back from DONE with corrected expectations.
        set_slot(2, 5'd7, 32'd15, 1'b1);
        set_slot(3, 5'd4, 32'd104, 1'b1);
        do_run(-1);
        chk("b2b_clr_fidx",  r0_fidx, 0);
        chk("b2b_clr_fdata", r0_fdata, 0);
        chk("b2b_busy",      r0_busy, 1);
        chk("b2b_pass",  64'(pass_o), 1);
        chk("b2b_fidx",  64'(fail_idx_o), 0);
        chk("b2b_fdata", 64'(fail_data_o), 0);

        // No halt: full budget of 32 cycles.
        halt_at = 1000;
        set_slot(1, 5'd0, 32'd0, 1'b0);
        set_slot(2, 5'd0, 32'd0, 1'b0);
        set_slot(3, 5'd0, 32'd0, 1'b0);
        do_run(-1);
        chk("t3_latency",    64'(lat), 42);
        chk("t3_timeout",    64'(timeout_o), 1);
        chk("t3_pass",       64'(pass_o), 0);
        chk("t3_nh_done",    64'(nh_done_o), 1);
        chk("t3_nh_timeout", 64'(nh_timeout_o), 1);
        chk("t3_nh_pass",    64'(nh_pass_o), 1);

        // Halt on the budget's last cycle beats the timeout.
        halt_at = 31;
        do_run(-1);
        chk("t4_latency", 64'(lat), 42);
        chk("t4_timeout", 64'(timeout_o), 0);
        chk("t4_pass",    64'(pass_o), 1);

        // start_i while busy is ignored.
        halt_at = 10;
        do_run(6);
        chk("t5_latency", 64'(lat), 21);
        chk("t5_pass",    64'(pass_o), 1);

        // Reset mid-RUN.
        @(negedge clk_i) start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1 rstn_i = 1'b0;
        #1;
        chk("t6_core_rstn", 64'(core_rstn_o), 0);
        chk("t6_busy",      64'(busy_o), 0);
        chk("t6_done",      64'(done_o), 0);
        chk("t6_raddr",     64'(rf_raddr_o), 0);
        @(negedge clk_i) rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("t6_idle_busy", 64'(busy_o), 0);
        do_run(-1);
        chk("t6_latency", 64'(lat), 21);
        chk("t6_pass",    64'(pass_o), 1);
        chk("t6_fidx",    64'(fail_idx_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jedro_1_test_monitor.md
# jedro_1_test_monitor

Parametrised self-checking run controller for jedro_1 core benches. It holds the core in reset, releases it, and runs it until an illegal instruction halts it or a cycle budget expires. It then drains the pipeline and checks up to NUM_CHECKS register-file entries against expected values through a register read port. One `start_i` performs one run; the result is reported as done, pass, timeout and first-failure data, replacing per-test hand-written check sequences.

## Interface
- DATA_WIDTH, 32, register data width
- NUM_CHECKS, 4, number of (address, expected) check slots; ≥1
- MAX_CYCLES, 32, run-phase cycle budget; ≥1
- RESET_CYCLES, 3, cycles core reset is held after start; ≥1
- DRAIN_CYCLES, 3, cycles waited after run ends before checking; ≥0
- REQUIRE_HALT, 1, when 1 a timeout forces pass_o=0
- clk_i  in  1  single clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- start_i  in  1  begin a run (sampled in IDLE/DONE only)
- illegal_instr_i  in  1  core decoder illegal-instruction flag
- rf_rdata_i  in  DATA_WIDTH  register-file read data, combinational from rf_raddr_o
- chk_addr_i  in  5*NUM_CHECKS  register address of slot k at bits [5k+4:5k]
- chk_exp_i  in  DATA_WIDTH*NUM_CHECKS  expected value of slot k
- chk_en_i  in  NUM_CHECKS  slot enable; disabled slots always match
- core_rstn_o  out  1  active-low reset to the core
- rf_raddr_o  out  5  register-file read address
- busy_o  out  1  high in RESET/RUN/DRAIN/CHECK
- done_o  out  1  high in DONE
- pass_o  out  1  result, valid when done_o
- timeout_o  out  1  run ended by budget, not by halt
- fail_idx_o  out  max(1,$clog2(NUM_CHECKS))  index of first failing enabled slot
- fail_data_o  out  DATA_WIDTH  data read at first failing slot

## Operation
- FSM states: IDLE → RESET → RUN → DRAIN → CHECK → DONE.
- IDLE: core_rstn_o=0. start_i=1 → RESET; clears timeout, fail flag, fail_idx, fail_data.
- RESET: core_rstn_o=0 for exactly RESET_CYCLES cycles → RUN.
- RUN: core_rstn_o=1; cycle counter starts at 0 and increments each cycle.
  - illegal_instr_i=1 → DRAIN with timeout unchanged (0).
  - counter==MAX_CYCLES-1 with illegal_instr_i=0 → DRAIN, timeout_o←1.
  - Both in the same cycle: illegal wins, timeout_o stays 0.
- DRAIN: exactly DRAIN_CYCLES cycles; when 0, RUN goes directly to CHECK.
- CHECK: index k runs 0..NUM_CHECKS-1, one slot per cycle.
  - rf_raddr_o = chk_addr_i slot k.
  - Slot k mismatches when chk_en_i[k] is set and rf_rdata_i ≠ chk_exp_i slot k; the compare is sampled at the clock edge.
  - On the first mismatch only, record fail_idx_o=k and fail_data_o=rf_rdata_i; later mismatches do not overwrite them.
  - After slot NUM_CHECKS-1 → DONE.
- DONE: pass_o = no mismatch AND NOT (timeout_o AND REQUIRE_HALT). Outputs are held.
  - start_i=1 → RESET, starting a new run with cleared results.
- core_rstn_o stays 1 in DRAIN, CHECK and DONE, so the core keeps running.
- start_i is ignored while busy_o=1.
- rf_raddr_o=0 outside CHECK.

## Timing
- Reset values:
  - FSM in IDLE.
  - core_rstn_o, busy_o, done_o, pass_o, timeout_o = 0.
  - fail_idx_o, fail_data_o, rf_raddr_o = 0.
- Asserting rstn_i at any time, including mid-RUN or mid-CHECK, immediately returns all outputs to reset values. core_rstn_o drops asynchronously.
- Registered outputs change on the rising edge after the state transition.
- Core reset release: core_rstn_o rises on the edge ending RESET_CYCLES.
- Latency from the start_i sample edge to done_o=1: RESET_CYCLES + R + DRAIN_CYCLES + NUM_CHECKS cycles.
  - R = run cycles, 1..MAX_CYCLES, including the terminating cycle.

## Test plan
- xori program (result 15 in x7), slot0={7,15,en}, others disabled, start → core halts on illegal instruction; done_o=1, pass_o=1, timeout_o=0, core_rstn_o low for 3 cycles.
- Same program, slot2={7,14,en}, slot0/1 matching → pass_o=0, fail_idx_o=2, fail_data_o=15. Add slot3 mismatching too → fail_idx_o still 2.
- Program with no illegal instruction, MAX_CYCLES=32:
  - REQUIRE_HALT=1 → timeout_o=1, pass_o=0.
  - REQUIRE_HALT=0 with matching checks → pass_o=1.
  - In both cases done_o rises 3+32+3+4=42 cycles after start.
- illegal_instr_i forced high on RUN cycle 31 (the budget's last cycle) → timeout_o=0.
- Edge cases for start and reset:
  - start_i pulsed during RUN → ignored, latency unchanged.
  - rstn_i low mid-RUN → core_rstn_o=0 and busy_o=0 at once.
  - After release, a fresh start completes normally with pass_o=1.
- Back-to-back: start_i in DONE after a failing run with chk_exp corrected → results cleared during RESET, then done_o=1 with pass_o=1 and fail_idx_o=0.
